// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with double-buffered period/compare registers.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting; default is edge-aligned.
module pwm_multi_gen #(
    parameter int unsigned CW  = 12,
    parameter int unsigned NCH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [2:0]     addr,
    input  logic [CW-1:0]  wdata,
    output logic [NCH-1:0] pwm_out,
    output logic           period_end
);

    logic [CW-1:0]  period_sh;
    logic [CW-1:0]  period_act;
    logic [CW-1:0]  cmp_sh  [NCH];
    logic [CW-1:0]  cmp_act [NCH];
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [NCH-1:0] pwm_nxt;
    logic           idle;
    logic           wrap;
    logic           loaded;

`ifdef PWM_CENTER_ALIGN_EN
    logic           dir_up;
    logic           dir_up_nxt;
`endif

    // Counter sequencing and per-channel compare
    always_comb begin
        idle    = (period_act == '0);
        cnt_nxt = cnt;
        wrap    = 1'b0;
        pwm_nxt = '0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_up_nxt = dir_up;
        if (idle) begin
            cnt_nxt    = '0;
            dir_up_nxt = 1'b1;
        end else if (dir_up) begin
            // Top value is held for two cycles: last up step, first down step
            if (cnt == period_act - CW'(1)) begin
                dir_up_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end else begin
            if (cnt == '0) begin
                dir_up_nxt = 1'b1;
                wrap       = 1'b1;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
`else
        if (idle) begin
            cnt_nxt = '0;
        end else if (cnt == period_act - CW'(1)) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
`endif
        for (int i = 0; i < int'(NCH); i++) begin
            pwm_nxt[i] = !idle && (cnt < cmp_act[i]);
        end
    end

    // Shadow writes, boundary loads, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh  <= '0;
            period_act <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                cmp_sh[i]  <= '0;
                cmp_act[i] <= '0;
            end
            cnt        <= '0;
            pwm_out    <= '0;
            loaded     <= 1'b0;
            period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up     <= 1'b1;
`endif
        end else begin
            if (wr_en) begin
                if (addr == 3'd0) begin
                    period_sh <= wdata;
                end
                for (int i = 0; i < int'(NCH); i++) begin
                    if (addr == 3'(i + 1)) begin
                        cmp_sh[i] <= wdata;
                    end
                end
            end
            // Active set only changes at a boundary, so a coincident write lands one period later
            if (idle || wrap) begin
                period_act <= period_sh;
                for (int i = 0; i < int'(NCH); i++) begin
                    cmp_act[i] <= cmp_sh[i];
                end
            end
            cnt        <= cnt_nxt;
            pwm_out    <= pwm_nxt;
            loaded     <= wrap;
            period_end <= loaded && !idle;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up     <= dir_up_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed self-checking bench for pwm_multi_gen (edge-aligned, or center-aligned
// when PWM_CENTER_ALIGN_EN is defined).
module tb_pwm_multi_gen;

    localparam int unsigned CW  = 12;
    localparam int unsigned NCH = 4;

    logic           clk;
    logic           rst_n;
    logic           wr_en;
    logic [2:0]     addr;
    logic [CW-1:0]  wdata;
    logic [NCH-1:0] pwm_out;
    logic           period_end;

    logic [NCH-1:0] pwm_hist [0:31];
    logic           pe_hist  [0:31];

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    pwm_multi_gen #(.CW(CW), .NCH(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [CW-1:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Record n cycles; optionally write during cycle wr_k (edge at its end)
    task automatic run_window(input int n, input int wr_k, input logic [2:0] wa, input logic [CW-1:0] wd);
        for (int k = 0; k < n; k++) begin
            pwm_hist[k] = pwm_out;
            pe_hist[k]  = period_end;
            if (k == wr_k) begin
                wr_en = 1'b1;
                addr  = wa;
                wdata = wd;
            end
            tick();
            wr_en = 1'b0;
        end
    endtask

    task automatic wait_pe(input int limit, output int cycles);
        cycles = 0;
        while (period_end !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    function automatic int unsigned ch_mask(input int ch, input int n);
        int unsigned m = 0;
        for (int k = 0; k < n; k++) begin
            if (pwm_hist[k][ch]) m = m | (32'd1 << k);
        end
        return m;
    endfunction

    function automatic int unsigned pe_mask(input int n);
        int unsigned m = 0;
        for (int k = 0; k < n; k++) begin
            if (pe_hist[k]) m = m | (32'd1 << k);
        end
        return m;
    endfunction

    function automatic int unsigned any_mask(input int n);
        int unsigned m = 0;
        for (int k = 0; k < n; k++) begin
            if (pwm_hist[k] != '0) m = m | (32'd1 << k);
        end
        return m;
    endfunction

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
        #1;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_pe", 32'(period_end), 0);
        tick();
        tick();
        rst_n = 1'b1;

        run_window(8, -1, 3'd0, '0);
        check("idle_pwm", any_mask(8), 0);
        check("idle_pe", pe_mask(8), 0);

`ifdef PWM_CENTER_ALIGN_EN
        wr(3'd1, 12'd3);
        wr(3'd0, 12'd10);
        wait_pe(40, lat);
        check("ca_first_lat", 32'(lat), 22);
        run_window(20, -1, 3'd0, '0);
        check("ca_ch0_w1", ch_mask(0, 20), 32'h000E0007);
        check("ca_pe_w1", pe_mask(20), 32'h00000001);
        check("ca_next_pe1", 32'(period_end), 1);
        run_window(20, -1, 3'd0, '0);
        check("ca_ch0_w2", ch_mask(0, 20), 32'h000E0007);
        check("ca_pe_w2", pe_mask(20), 32'h00000001);
        check("ca_next_pe2", 32'(period_end), 1);
`else
        wr(3'd1, 12'd3);
        wr(3'd2, 12'd0);
        wr(3'd3, 12'd4095);
        wr(3'd4, 12'd5);
        wr(3'd0, 12'd10);
        wait_pe(40, lat);
        check("first_lat", 32'(lat), 12);

        run_window(10, -1, 3'd0, '0);
        check("w1_ch0", ch_mask(0, 10), 32'h007);
        check("w1_ch1_zero", ch_mask(1, 10), 32'h000);
        check("w1_ch2_full", ch_mask(2, 10), 32'h3FF);
        check("w1_ch3", ch_mask(3, 10), 32'h01F);
        check("w1_pe", pe_mask(10), 32'h001);

        // cmp 3->7 written while cnt == 5
        run_window(10, 4, 3'd1, 12'd7);
        check("w2_ch0_keep3", ch_mask(0, 10), 32'h007);
        check("w2_pe", pe_mask(10), 32'h001);

        // period 20 written on the wrap edge (cnt == 9)
        run_window(10, 8, 3'd0, 12'd20);
        check("w3_ch0_new7", ch_mask(0, 10), 32'h07F);
        check("w3_pe", pe_mask(10), 32'h001);

        run_window(10, -1, 3'd0, '0);
        check("w4_still10_pe", pe_mask(10), 32'h001);
        check("w4_ch0", ch_mask(0, 10), 32'h07F);

        run_window(20, -1, 3'd0, '0);
        check("w5_p20_pe", pe_mask(20), 32'h00001);
        check("w5_ch0", ch_mask(0, 20), 32'h0007F);
        check("w5_ch2_full", ch_mask(2, 20), 32'hFFFFF);
        check("w5_ch3", ch_mask(3, 20), 32'h0001F);
        check("w5_next_pe", 32'(period_end), 1);

        // Asynchronous reset while ch0 is high and period_end is asserted
        check("pre_rst_ch0", 32'(pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_pe", 32'(period_end), 0);
        tick();
        tick();
        rst_n = 1'b1;

        wr(3'd5, 12'd8);
        wr(3'd6, 12'd9);
        wr(3'd7, 12'd9);
        run_window(12, -1, 3'd0, '0);
        check("badaddr_idle_pwm", any_mask(12), 0);
        check("badaddr_idle_pe", pe_mask(12), 0);

        wr(3'd4, 12'd10);
        wr(3'd0, 12'd10);
        wait_pe(40, lat);
        check("post_rst_lat", 32'(lat), 12);
        run_window(10, -1, 3'd0, '0);
        check("post_ch0_zero", ch_mask(0, 10), 32'h000);
        check("post_ch1_zero", ch_mask(1, 10), 32'h000);
        check("post_ch2_zero", ch_mask(2, 10), 32'h000);
        check("post_ch3_eqP", ch_mask(3, 10), 32'h3FF);
        check("post_pe", pe_mask(10), 32'h001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_gen.md
PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

Interface
REQ-001 SHALL have parameter CW, default 12, meaning counter, period and compare width in bits (2..16).
REQ-002 SHALL have parameter NCH, default 4, meaning number of PWM channels (1..7).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  register write strobe, sampled at the rising edge of clk.
REQ-006 SHALL have port addr  input  3  register select: 0 = period, 1..NCH = compare of channel addr-1.
REQ-007 SHALL have port wdata  input  CW  write data, unsigned.
REQ-008 SHALL have port pwm_out  output  NCH  registered PWM outputs, bit i = channel i.
REQ-009 SHALL have port period_end  output  1  registered one-cycle pulse marking each period boundary.

Function
REQ-010 SHALL hold one shadow and one active register for the period, and the same pair for each channel compare.
REQ-011 SHALL load wdata into the shadow register selected by addr on a clk edge with wr_en=1.
REQ-012 SHALL ignore writes with addr > NCH, leaving all registers unchanged.
REQ-013 SHALL count cnt (CW bits) 0,1,...,P-1 and then wrap to 0 while active period P != 0.
REQ-014 SHALL copy all shadow registers to the active registers on the edge where cnt wraps (cnt == P-1).
REQ-015 SHALL, while P == 0 (idle), hold cnt at 0, copy shadow to active on every edge, and drive pwm_out and period_end to 0.
REQ-016 SHALL drive pwm_out[i] at edge t+1 as 1 if cnt(t) < cmp_active[i], else 0 (one-cycle latency).
REQ-017 SHALL keep pwm_out[i] constantly 0 when cmp = 0.
REQ-018 SHALL keep pwm_out[i] constantly 1 when cmp >= P.
REQ-019 SHALL pulse period_end high for exactly one cycle, on the edge after each copy of REQ-014.
REQ-020 SHALL, when a write coincides with the REQ-014 load edge, copy the old shadow value to active; the new value takes effect one period later.
REQ-021 SHALL never apply a shadow value mid-period: no truncated or extended periods or pulses.
REQ-022 SHALL compare unsigned values at CW bits with no percent scaling; duty resolution = 1/P.

Reset
REQ-023 SHALL, while rst_n = 0, asynchronously clear cnt, all shadow and active registers, pwm_out and period_end to 0.
REQ-024 SHALL, after reset release, remain idle per REQ-015 until a nonzero period is written.

Configuration
REQ-025 SHALL, with macro PWM_CENTER_ALIGN_EN defined, count in up/down mode.
- Sequence: cnt = 0,1,...,P-1, then P-1,...,1,0.
- Length: period of 2P cycles.
- Direction flag: resets to up.
- REQ-014 load and REQ-019 pulse: occur at the end of the down phase (cnt == 0, down) instead of at cnt == P-1.
- Output: high for 2*cmp cycles, centred on the period boundary.
REQ-026 SHALL, with PWM_CENTER_ALIGN_EN undefined, implement edge-aligned mode only, with no direction logic present.

Verification
REQ-027 SHALL cover: reset, write period=10, ch0 cmp=3 → ch0 high 3 of every 10 cycles; period_end every 10 cycles.
REQ-028 SHALL cover: ch1 cmp=0 and ch2 cmp=4095 with P=10 → ch1 constantly 0, ch2 constantly 1.
REQ-029 SHALL cover: ch0 cmp changed 3→7 at cnt=5 → current period keeps 3 high cycles; next period has 7.
REQ-030 SHALL cover: write period=20 on the wrap edge → next period is still 10; the one after is 20.
REQ-031 SHALL cover: rst_n low mid-pulse, also writes to addr 6 with NCH=4 → outputs 0 immediately without a clock; bad-address write has no effect.
REQ-032 SHALL cover: with PWM_CENTER_ALIGN_EN, P=10, cmp=3 → period 20 cycles; ch0 high 6 contiguous cycles spanning each period_end.
